// File: rtl/led_pattern_pkg.sv
// Shared types and configuration field layout for the LED pattern generator.
// The breathe feature is enabled by LED_PATTERN_BREATHE_EN.
package led_pattern_pkg;

    localparam int CFG_W    = 4;
    localparam int MODE_W   = 2;
    localparam int MODE_LSB = 0;
    localparam int RATE_W   = 2;
    localparam int RATE_LSB = 2;
    localparam int PHASE_W  = 4;
    localparam int SUB_W    = 3;

    typedef enum logic [MODE_W-1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    typedef enum logic {
        RAMP_UP   = 1'b0,
        RAMP_DOWN = 1'b1
    } ramp_state_e;

    // Last ramp sub-count before a level step: 2^rate strobes per step.
    function automatic logic [SUB_W-1:0] ramp_div_max(input logic [RATE_W-1:0] rate);
        case (rate)
            2'd0:    ramp_div_max = 3'd0;
            2'd1:    ramp_div_max = 3'd1;
            2'd2:    ramp_div_max = 3'd3;
            default: ramp_div_max = 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/led_pattern_ch.sv
// One LED channel: config register, blink phase, breathe ramp FSM and output register.
// Ramp FSM and PWM compare exist only when LED_PATTERN_BREATHE_EN is defined.
module led_pattern_ch
    import led_pattern_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             tick,
`ifdef LED_PATTERN_BREATHE_EN
    input  logic             ramp_strobe,
    input  logic [PWM_W-1:0] pwm_cnt,
`endif
    input  logic             cfg_we,
    input  logic [CFG_W-1:0] cfg_wdata,
    output logic [CFG_W-1:0] cfg,
    output logic             led
);

    mode_e              mode_r;
    logic [RATE_W-1:0]  rate_r;
    logic [PHASE_W-1:0] phase_r;
    logic               led_r;
    logic               led_nxt;
    logic               blink_s;

    assign blink_s = phase_r[rate_r];
    assign led     = led_r;

    // Config readback in the shared field layout
    always_comb begin
        cfg = {CFG_W{1'b0}};
        cfg[MODE_LSB +: MODE_W] = mode_r;
        cfg[RATE_LSB +: RATE_W] = rate_r;
    end

    // Configuration register; reset pattern is BLINK at the fastest rate
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mode_r <= MODE_BLINK;
            rate_r <= 2'd0;
        end else if (cfg_we) begin
            mode_r <= mode_e'(cfg_wdata[MODE_LSB +: MODE_W]);
            rate_r <= cfg_wdata[RATE_LSB +: RATE_W];
        end
    end

    // Blink phase advances on every prescaler tick regardless of mode
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_r <= 4'd0;
        end else if (tick) begin
            phase_r <= phase_r + 4'd1;
        end
    end

`ifdef LED_PATTERN_BREATHE_EN
    localparam logic [PWM_W-1:0] LEVEL_MAX  = {PWM_W{1'b1}};
    localparam logic [PWM_W-1:0] LEVEL_ZERO = {PWM_W{1'b0}};
    localparam logic [PWM_W-1:0] LEVEL_ONE  = PWM_W'(1'b1);

    ramp_state_e      state_r;
    ramp_state_e      state_nxt;
    logic [PWM_W-1:0] level_r;
    logic [PWM_W-1:0] level_nxt;
    logic [SUB_W-1:0] sub_r;
    logic [SUB_W-1:0] sub_nxt;
    logic             mode_change_s;

    assign mode_change_s = cfg_we && (cfg_wdata[MODE_LSB +: MODE_W] != mode_r);

    // Ramp state registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= RAMP_UP;
            level_r <= LEVEL_ZERO;
            sub_r   <= 3'd0;
        end else begin
            state_r <= state_nxt;
            level_r <= level_nxt;
            sub_r   <= sub_nxt;
        end
    end

    // A mode change restarts the ramp; otherwise step once every 2^rate strobes, never wrapping
    always_comb begin
        state_nxt = state_r;
        level_nxt = level_r;
        sub_nxt   = sub_r;
        if (mode_change_s) begin
            state_nxt = RAMP_UP;
            level_nxt = LEVEL_ZERO;
            sub_nxt   = 3'd0;
        end else if (ramp_strobe && (mode_r == MODE_BREATHE)) begin
            if (sub_r == ramp_div_max(rate_r)) begin
                sub_nxt = 3'd0;
                case (state_r)
                    RAMP_UP: begin
                        level_nxt = (level_r == LEVEL_MAX) ? level_r : level_r + LEVEL_ONE;
                        state_nxt = (level_r >= LEVEL_MAX - LEVEL_ONE) ? RAMP_DOWN : RAMP_UP;
                    end
                    RAMP_DOWN: begin
                        level_nxt = (level_r == LEVEL_ZERO) ? level_r : level_r - LEVEL_ONE;
                        state_nxt = (level_r <= LEVEL_ONE) ? RAMP_UP : RAMP_DOWN;
                    end
                    default: begin
                        state_nxt = RAMP_UP;
                        level_nxt = LEVEL_ZERO;
                    end
                endcase
            end else begin
                sub_nxt = sub_r + 3'd1;
            end
        end else begin
            sub_nxt = sub_r;
        end
    end
`endif

    // Output selection from the current mode
    always_comb begin
        led_nxt = 1'b0;
        case (mode_r)
            MODE_OFF:     led_nxt = 1'b0;
            MODE_ON:      led_nxt = 1'b1;
            MODE_BLINK:   led_nxt = blink_s;
`ifdef LED_PATTERN_BREATHE_EN
            MODE_BREATHE: led_nxt = (pwm_cnt < level_r);
`else
            MODE_BREATHE: led_nxt = blink_s;
`endif
            default:      led_nxt = 1'b0;
        endcase
    end

    // LED drive register, frozen while the generator is disabled
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            led_r <= 1'b0;
        end else if (en) begin
            led_r <= led_nxt;
        end
    end

endmodule

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: shared prescaler/PWM counter, per-channel pattern logic.
// Define LED_PATTERN_BREATHE_EN to build the BREATHE mode; otherwise mode 3 blinks.
module led_pattern_gen
    import led_pattern_pkg::*;
#(
    parameter  int NUM_CH = 10,
    parameter  int DIV_W  = 24,
    parameter  int PWM_W  = 8,
    localparam int ADDR_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              en,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [CFG_W-1:0]  cfg_wdata,
    output logic [CFG_W-1:0]  cfg_rdata,
    output logic [NUM_CH-1:0] led
);

    logic [DIV_W-1:0] presc_r;
    logic             tick_s;
    logic [CFG_W-1:0] ch_cfg [NUM_CH];

    // Shared prescaler, wraps at all-ones
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            presc_r <= {DIV_W{1'b0}};
        end else if (en) begin
            presc_r <= presc_r + DIV_W'(1'b1);
        end
    end

    assign tick_s = en && (&presc_r);

`ifdef LED_PATTERN_BREATHE_EN
    logic [PWM_W-1:0] pwm_r;
    logic             ramp_strobe_s;

    // Shared free-running PWM counter; its wrap paces the breathe ramps
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pwm_r <= {PWM_W{1'b0}};
        end else if (en) begin
            pwm_r <= pwm_r + PWM_W'(1'b1);
        end
    end

    assign ramp_strobe_s = en && (&pwm_r);
`endif

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        led_pattern_ch #(
            .PWM_W(PWM_W)
        ) u_ch (
            .clk        (clk),
            .reset_n    (reset_n),
            .en         (en),
            .tick       (tick_s),
`ifdef LED_PATTERN_BREATHE_EN
            .ramp_strobe(ramp_strobe_s),
            .pwm_cnt    (pwm_r),
`endif
            .cfg_we     (cfg_we && (cfg_addr == ADDR_W'(i))),
            .cfg_wdata  (cfg_wdata),
            .cfg        (ch_cfg[i]),
            .led        (led[i])
        );
    end

    // Readback mux; addresses beyond the last channel read as zero
    always_comb begin
        cfg_rdata = {CFG_W{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_rdata = cfg_rdata | (ch_cfg[i] & {CFG_W{cfg_addr == ADDR_W'(i)}});
        end
    end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Directed bench for led_pattern_gen (DIV_W=4, PWM_W=3); breathe checks only when
// LED_PATTERN_BREATHE_EN is defined.
module tb_led_pattern_gen;

    localparam int NUM_CH = 10;
    localparam int DIV_W  = 4;
    localparam int PWM_W  = 3;

    logic              clk;
    logic              reset_n;
    logic              en;
    logic              cfg_we;
    logic [3:0]        cfg_addr;
    logic [3:0]        cfg_wdata;
    logic [3:0]        cfg_rdata;
    logic [NUM_CH-1:0] led;

    int total;
    int bad;

    // Pattern-level reference state
    logic [1:0]        m_mode [NUM_CH];
    logic [1:0]        m_rate [NUM_CH];
    logic [3:0]        m_phase;
    logic [NUM_CH-1:0] m_led;
    int                m_presc;
    int                m_pwm;

    typedef struct {
        logic       en;
        logic       we;
        logic [3:0] addr;
        logic [3:0] wdata;
        int         hold;
        logic [3:0] rd_addr;
        logic [3:0] exp_rdata;
    } vec_t;

    vec_t tbl [10];

    led_pattern_gen #(
        .NUM_CH(NUM_CH),
        .DIV_W (DIV_W),
        .PWM_W (PWM_W)
    ) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .cfg_we   (cfg_we),
        .cfg_addr (cfg_addr),
        .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata),
        .led      (led)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_mode[i] = 2'd2;
            m_rate[i] = 2'd0;
        end
        m_phase = 4'd0;
        m_led   = {NUM_CH{1'b0}};
        m_presc = 0;
        m_pwm   = 0;
    endtask

    // One clock with the given inputs; led is compared to the pattern model after the edge
    task automatic cyc(input logic e, input logic we, input logic [3:0] a, input logic [3:0] d);
        logic [NUM_CH-1:0] nxt;
        logic [NUM_CH-1:0] mask;
        en        = e;
        cfg_we    = we;
        cfg_addr  = a;
        cfg_wdata = d;
        nxt  = m_led;
        mask = {NUM_CH{1'b0}};
        for (int i = 0; i < NUM_CH; i++) begin
`ifdef LED_PATTERN_BREATHE_EN
            mask[i] = (m_mode[i] == 2'd3);
`endif
            if (e) begin
                case (m_mode[i])
                    2'd0:    nxt[i] = 1'b0;
                    2'd1:    nxt[i] = 1'b1;
                    default: nxt[i] = m_phase[m_rate[i]];
                endcase
            end
        end
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        m_led  = nxt;
        if (e) begin
            if (m_presc == 15) m_phase = m_phase + 4'd1;
            m_presc = (m_presc + 1) % 16;
            m_pwm   = (m_pwm + 1) % 8;
        end
        if (we && (a < NUM_CH)) begin
            m_mode[a] = d[1:0];
            m_rate[a] = d[3:2];
        end
        check("led", 32'(led & ~mask), 32'(m_led & ~mask));
    endtask

`ifdef LED_PATTERN_BREATHE_EN
    int   lv_exp [16] = '{1, 2, 3, 4, 5, 6, 7, 6, 5, 4, 3, 2, 1, 0, 1, 2};
    int   highs;
    logic frozen;
`endif

    initial begin
        total     = 0;
        bad       = 0;
        reset_n   = 1'b0;
        en        = 1'b0;
        cfg_we    = 1'b0;
        cfg_addr  = 4'd0;
        cfg_wdata = 4'd0;

        tbl[0] = '{1'b1, 1'b1, 4'd2,  4'hA, 130, 4'd2,  4'hA};
        tbl[1] = '{1'b1, 1'b1, 4'd1,  4'h0, 3,   4'd1,  4'h0};
        tbl[2] = '{1'b1, 1'b1, 4'd1,  4'h1, 3,   4'd1,  4'h1};
        tbl[3] = '{1'b1, 1'b1, 4'd10, 4'h1, 20,  4'd10, 4'h0};
        tbl[4] = '{1'b1, 1'b1, 4'd9,  4'h7, 40,  4'd9,  4'h7};
        tbl[5] = '{1'b1, 1'b1, 4'd9,  4'h2, 20,  4'd15, 4'h0};
        tbl[6] = '{1'b1, 1'b1, 4'd0,  4'hE, 10,  4'd0,  4'hE};
        tbl[7] = '{1'b0, 1'b0, 4'd0,  4'h0, 50,  4'd0,  4'hE};
        tbl[8] = '{1'b0, 1'b1, 4'd3,  4'h1, 5,   4'd3,  4'h1};
        tbl[9] = '{1'b1, 1'b1, 4'd3,  4'h2, 20,  4'd3,  4'h2};

        repeat (3) @(posedge clk);
        #1;
        check("reset_led", 32'(led), 32'd0);
        check("reset_cfg", 32'(cfg_rdata), 32'h2);

        // All channels blink in unison: first rise 17 edges after release
        reset_n = 1'b1;
        model_reset();
        for (int k = 1; k <= 48; k++) begin
            cyc(1'b1, 1'b0, 4'd0, 4'd0);
            if (k == 16) check("rise_pre", 32'(led), 32'd0);
            if (k == 17) check("rise_first", 32'(led), 32'h3FF);
        end

        for (int v = 0; v < 10; v++) begin
            cyc(tbl[v].en, tbl[v].we, tbl[v].addr, tbl[v].wdata);
            for (int h = 0; h < tbl[v].hold; h++) begin
                cyc(tbl[v].en, 1'b0, tbl[v].addr, 4'd0);
            end
            cfg_addr = tbl[v].rd_addr;
            #1;
            check("rdata", 32'(cfg_rdata), 32'(tbl[v].exp_rdata));
        end

`ifdef LED_PATTERN_BREATHE_EN
        // ch0 BREATHE rate 0: duty per 8-cycle PWM window follows the 0..7..0 triangle
        cyc(1'b1, 1'b1, 4'd0, 4'h3);
        do begin
            cyc(1'b1, 1'b0, 4'd0, 4'd0);
        end while (m_pwm != 0);
        for (int n = 0; n < 16; n++) begin
            highs = 0;
            for (int j = 0; j < 8; j++) begin
                cyc(1'b1, (n == 8) && (j == 0), 4'd0, 4'h3);
                highs += int'(led[0]);
                if ((n == 4) && (j == 2)) begin
                    frozen = led[0];
                    for (int f = 0; f < 50; f++) begin
                        cyc(1'b0, 1'b0, 4'd0, 4'd0);
                        check("freeze_led0", 32'(led[0]), 32'(frozen));
                    end
                end
            end
            check("breathe_duty", 32'(highs), 32'(lv_exp[n]));
        end
        cfg_addr = 4'd0;
        #1;
        check("breathe_rdata", 32'(cfg_rdata), 32'h3);
`else
        // Without the breathe build, mode 3 blinks at its rate
        cyc(1'b1, 1'b1, 4'd0, 4'h3);
        for (int k = 0; k < 64; k++) begin
            cyc(1'b1, 1'b0, 4'd0, 4'd0);
        end
        cfg_addr = 4'd0;
        #1;
        check("mode3_rdata", 32'(cfg_rdata), 32'h3);
`endif

        // Asynchronous reset in the middle of a write and a ramp
        cfg_we    = 1'b1;
        cfg_addr  = 4'd4;
        cfg_wdata = 4'h1;
        #3;
        reset_n = 1'b0;
        #1;
        check("async_reset_led", 32'(led), 32'd0);
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < NUM_CH; i++) begin
            cfg_addr = 4'(i);
            #1;
            check("reset_cfg_ch", 32'(cfg_rdata), 32'h2);
        end
        reset_n = 1'b1;
        model_reset();
        for (int k = 1; k <= 20; k++) begin
            cyc(1'b1, 1'b0, 4'd0, 4'd0);
            if (k == 16) check("rerise_pre", 32'(led), 32'd0);
            if (k == 17) check("rerise_first", 32'(led), 32'h3FF);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/led_pattern_gen.md
LED_PATTERN_GEN -- requirements
Module: led_pattern_gen

Interface
REQ-001 SHALL have parameter NUM_CH, default 10, number of independent LED channels (1..32).
REQ-002 SHALL have parameter DIV_W, default 24, prescaler width; tick period = 2^DIV_W clk cycles.
REQ-003 SHALL have parameter PWM_W, default 8, PWM counter and brightness width.
REQ-004 SHALL have port clk  input  1  system clock, all logic on rising edge.
REQ-005 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port en  input  1  synchronous run enable; low freezes prescaler, PWM counter, phase and ramp state.
REQ-007 SHALL have port cfg_we  input  1  configuration write strobe, single cycle.
REQ-008 SHALL have port cfg_addr  input  $clog2(NUM_CH) (min 1)  channel index for write and readback.
REQ-009 SHALL have port cfg_wdata  input  4  {rate[1:0], mode[1:0]}.
REQ-010 SHALL have port cfg_rdata  output  4  combinational readback of channel cfg_addr config; 0 if out of range.
REQ-011 SHALL have port led  output  NUM_CH  registered per-channel LED drive.

Function
REQ-012 Prescaler SHALL be a DIV_W-bit up-counter wrapping at all-ones; tick SHALL be a one-cycle pulse in the cycle the prescaler equals all-ones and en=1.
REQ-013 Modes SHALL be: 0 OFF (led=0), 1 ON (led=1), 2 BLINK, 3 BREATHE.
REQ-014 Each channel SHALL hold a 4-bit phase counter incremented on every tick; BLINK output SHALL equal phase[rate], giving half-period 2^rate ticks.
REQ-015 A PWM_W-bit free-running PWM counter SHALL advance each en=1 cycle; ramp strobe SHALL pulse on its wrap to 0.
REQ-016 BREATHE SHALL run a per-channel two-state FSM UP/DOWN with PWM_W-bit level; level changes by 1 every 2^rate ramp strobes.
REQ-017 UP: increment; on reaching 2^PWM_W-1 SHALL transition to DOWN in the same update. DOWN: decrement; on reaching 0 SHALL transition to UP. Level SHALL never wrap.
REQ-018 BREATHE output SHALL be 1 when PWM counter < level (level 0 gives constant 0).
REQ-019 led SHALL be registered: output reflects internal state with exactly one clk of latency.
REQ-020 cfg write SHALL take effect in the cycle after cfg_we; cfg_addr >= NUM_CH SHALL be ignored.
REQ-021 A write that changes mode SHALL reset that channel's FSM to UP, level 0, and ramp sub-counter to 0; phase counter SHALL be unaffected; rewriting the same mode SHALL not disturb state.
REQ-022 Write coincident with tick or ramp strobe: new config SHALL apply from the next cycle; current-cycle update SHALL use old config.
REQ-023 en=0 SHALL hold led values and all counters; cfg writes SHALL still be accepted.

Reset
REQ-024 On reset_n low: prescaler, PWM counter, phase counters, levels, ramp sub-counters = 0; FSM = UP; led = 0.
REQ-025 Reset config SHALL be mode BLINK, rate 0 for every channel (all LEDs blink in unison after reset).
REQ-026 Reset assertion mid-breathe or mid-write SHALL discard the in-progress update.

Configuration
REQ-027 Macro LED_PATTERN_BREATHE_EN defined: BREATHE mode, PWM counter and FSM SHALL be built as specified.
REQ-028 Macro LED_PATTERN_BREATHE_EN undefined: PWM counter, level and FSM logic SHALL be absent; mode 3 SHALL behave exactly as BLINK; cfg_rdata SHALL still return the written value 3.

Structure
REQ-029 Package led_pattern_pkg SHALL hold the mode enum (OFF/ON/BLINK/BREATHE), the ramp FSM state enum, and cfg field widths/offsets.
REQ-030 Sub-module led_pattern_ch SHALL implement one channel (config reg, phase, FSM, output reg), instantiated NUM_CH times; prescaler and PWM counter SHALL be shared in the top.

Verification
REQ-031 DIV_W=4, reset release, en=1 -> all led toggle together every 16 cycles, first rise at cycle 17 after release.
REQ-032 Write ch2 {rate=2,mode=BLINK} -> led[2] half-period 64 cycles; other channels unchanged.
REQ-033 PWM_W=3, ch0 BREATHE rate 0 -> level 0..7..0 stepping every 8 cycles, duty = level/8, full triangle 112 cycles.
REQ-034 Write ch1 OFF then ON -> led[1] = 0 then 1, each one cycle after the following edge; cfg_rdata returns 0 then 1.
REQ-035 Hold en=0 for 50 cycles mid-breathe -> led and level frozen; resume continues without skipping a level.
REQ-036 cfg_addr=NUM_CH write, and reset asserted mid-ramp -> no channel changes; after reset all outputs 0, config BLINK rate 0.
